// File: rtl/video_frame_source.sv
`default_nettype none
// ============================================================================
// Module   : video_frame_source
// Brief    : Reads one frame in raster order from a synchronous frame memory
//            and streams it as 8-bit pixels with row/frame sideband.
// Revision : 1.0 - initial release
// ============================================================================
module video_frame_source #(
    parameter int IMG_WIDTH  = 1920,
    parameter int IMG_HEIGHT = 1080,
    parameter int ADDR_WIDTH = 21,
    parameter int BASE_ADDR  = 0,
    parameter int H_GAP      = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [7:0]            mem_rdata,
    output logic [7:0]            m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tlast,
    output logic                  m_tuser
);
    localparam int XW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int GW = (H_GAP      > 1) ? $clog2(H_GAP)      : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_GAP   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [XW-1:0]         x_q, x_d;
    logic [YW-1:0]         y_q, y_d;
    logic [GW-1:0]         gap_cnt_q, gap_cnt_d;
    logic [ADDR_WIDTH-1:0] offset_q, offset_d;
    logic                  inflight_q, inflight_d;
    logic                  infl_last_q, infl_last_d;
    logic                  infl_sof_q, infl_sof_d;
    logic                  head_vld_q, head_vld_d;
    logic                  tail_vld_q, tail_vld_d;
    logic [7:0]            head_data_q, head_data_d;
    logic [7:0]            tail_data_q, tail_data_d;
    logic                  head_last_q, head_last_d;
    logic                  head_sof_q, head_sof_d;
    logic                  tail_last_q, tail_last_d;
    logic                  tail_sof_q, tail_sof_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  pop;
    logic                  row_end;
    logic                  frame_end;
    logic [2:0]            level;

    always_comb begin
        pop       = head_vld_q & m_tready;
        // Slots committed after this cycle's pop: buffered + arriving read.
        level     = 3'(head_vld_q) + 3'(tail_vld_q) + 3'(inflight_q) - 3'(pop);
        row_end   = (x_q == XW'(IMG_WIDTH - 1));
        frame_end = row_end && (y_q == YW'(IMG_HEIGHT - 1));
        mem_rd_en = (state_q == ST_RUN) && (level < 3'd2);
        mem_addr  = mem_rd_en ? (ADDR_WIDTH'(BASE_ADDR) + offset_q) : '0;
    end

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        gap_cnt_d   = gap_cnt_q;
        offset_d    = offset_q;
        done_d      = 1'b0;
        inflight_d  = mem_rd_en;
        infl_last_d = row_end;
        infl_sof_d  = (x_q == '0) && (y_q == '0);

        case (state_q)
            ST_IDLE: begin
                // The done cycle is already IDLE; a start there is ignored.
                if (start && !done_q) begin
                    state_d  = ST_RUN;
                    x_d      = '0;
                    y_d      = '0;
                    offset_d = '0;
                end
            end
            ST_RUN: begin
                if (mem_rd_en) begin
                    offset_d = offset_q + ADDR_WIDTH'(1);
                    if (row_end) begin
                        x_d = '0;
                        if (frame_end) begin
                            y_d     = '0;
                            state_d = ST_DRAIN;
                        end else begin
                            y_d = y_q + YW'(1);
                            if (H_GAP > 0) begin
                                state_d   = ST_GAP;
                                gap_cnt_d = '0;
                            end
                        end
                    end else begin
                        x_d = x_q + XW'(1);
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GW'(H_GAP - 1)) begin
                    state_d = ST_RUN;
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end
            default: begin
                if (pop && !tail_vld_q && !inflight_q) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_comb begin
        head_vld_d  = head_vld_q;
        tail_vld_d  = tail_vld_q;
        head_data_d = head_data_q;
        head_last_d = head_last_q;
        head_sof_d  = head_sof_q;
        tail_data_d = tail_data_q;
        tail_last_d = tail_last_q;
        tail_sof_d  = tail_sof_q;

        if (pop) begin
            if (tail_vld_q) begin
                head_data_d = tail_data_q;
                head_last_d = tail_last_q;
                head_sof_d  = tail_sof_q;
                tail_vld_d  = 1'b0;
            end else begin
                head_vld_d  = 1'b0;
                head_data_d = '0;
                head_last_d = 1'b0;
                head_sof_d  = 1'b0;
            end
        end

        if (inflight_q) begin
            if (!head_vld_d) begin
                head_vld_d  = 1'b1;
                head_data_d = mem_rdata;
                head_last_d = infl_last_q;
                head_sof_d  = infl_sof_q;
            end else begin
                tail_vld_d  = 1'b1;
                tail_data_d = mem_rdata;
                tail_last_d = infl_last_q;
                tail_sof_d  = infl_sof_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            gap_cnt_q   <= '0;
            offset_q    <= '0;
            inflight_q  <= 1'b0;
            infl_last_q <= 1'b0;
            infl_sof_q  <= 1'b0;
            head_vld_q  <= 1'b0;
            tail_vld_q  <= 1'b0;
            head_data_q <= '0;
            head_last_q <= 1'b0;
            head_sof_q  <= 1'b0;
            tail_data_q <= '0;
            tail_last_q <= 1'b0;
            tail_sof_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            gap_cnt_q   <= gap_cnt_d;
            offset_q    <= offset_d;
            inflight_q  <= inflight_d;
            infl_last_q <= infl_last_d;
            infl_sof_q  <= infl_sof_d;
            head_vld_q  <= head_vld_d;
            tail_vld_q  <= tail_vld_d;
            head_data_q <= head_data_d;
            head_last_q <= head_last_d;
            head_sof_q  <= head_sof_d;
            tail_data_q <= tail_data_d;
            tail_last_q <= tail_last_d;
            tail_sof_q  <= tail_sof_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign m_tvalid = head_vld_q;
    assign m_tdata  = head_data_q;
    assign m_tlast  = head_last_q;
    assign m_tuser  = head_sof_q;

endmodule
`default_nettype wire

// File: tb/tb_video_frame_source.sv
`default_nettype none
// ============================================================================
// Module   : tb_video_frame_source
// Brief    : Self-checking bench; instance 0 has H_GAP=0, instance 1 H_GAP=2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_video_frame_source;
    localparam int W    = 4;
    localparam int H    = 3;
    localparam int NPIX = W * H;
    localparam int BASE = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      start, busy, done, rd_en, tvalid, tready, tlast, tuser;
    logic [1:0][7:0] addr, tdata;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    bit all_ready = 1'b0;

    int beat_idx [2];
    int rd_idx [2];
    int since_rd [2];
    int first_rd_cyc [2];
    bit seen_valid [2];
    bit final_prev [2];
    bit vprev [2];
    bit popprev [2];
    bit pop_now;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        logic [7:0] rdata;
        video_frame_source #(
            .IMG_WIDTH (W),
            .IMG_HEIGHT(H),
            .ADDR_WIDTH(8),
            .BASE_ADDR (BASE),
            .H_GAP     ((gi == 0) ? 0 : 2)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .start    (start[gi]),
            .busy     (busy[gi]),
            .done     (done[gi]),
            .mem_rd_en(rd_en[gi]),
            .mem_addr (addr[gi]),
            .mem_rdata(rdata),
            .m_tdata  (tdata[gi]),
            .m_tvalid (tvalid[gi]),
            .m_tready (tready[gi]),
            .m_tlast  (tlast[gi]),
            .m_tuser  (tuser[gi])
        );
        // Memory holds mem[a] = a; junk on the bus when no read was issued.
        always @(posedge clk) rdata <= rd_en[gi] ? addr[gi] : 8'($urandom);
    end

    task automatic check(input string tag, input int idx, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s[%0d] @cyc %0d: got 0x%0h expected 0x%0h", tag, idx, cyc, got, exp);
        end
    endtask

    function automatic int hgap(input int i);
        return (i == 0) ? 0 : 2;
    endfunction

    function automatic logic [31:0] outs(input int i);
        return {10'b0, busy[i], done[i], rd_en[i], tvalid[i], tlast[i], tuser[i],
                addr[i], tdata[i]};
    endfunction

    task automatic clear_frame(input int i);
        beat_idx[i]   = 0;
        rd_idx[i]     = 0;
        since_rd[i]   = 0;
        seen_valid[i] = 1'b0;
    endtask

    // Reference model: beat k of a frame is pixel k of the raster scan.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                clear_frame(i);
                final_prev[i] = 1'b0;
                vprev[i]      = 1'b0;
                popprev[i]    = 1'b0;
            end else begin
                pop_now = tvalid[i] && tready[i];
                if (tvalid[i]) begin
                    if (!seen_valid[i]) begin
                        check("first_lat", i, cyc - first_rd_cyc[i], 2);
                        seen_valid[i] = 1'b1;
                    end
                    if (beat_idx[i] >= NPIX) begin
                        check("extra_beat", i, beat_idx[i], NPIX - 1);
                    end else begin
                        check("tdata", i, tdata[i], (BASE + beat_idx[i]) % 256);
                        check("tlast", i, tlast[i], (beat_idx[i] % W) == W - 1);
                        check("tuser", i, tuser[i], beat_idx[i] == 0);
                    end
                end else if (vprev[i] && !popprev[i]) begin
                    check("valid_drop", i, tvalid[i], 1);
                end
                check("done", i, done[i], final_prev[i]);
                if (done[i] && all_ready) check("tail_lat", i, since_rd[i], 2);
                if (rd_en[i]) begin
                    check("rd_addr", i, addr[i], (BASE + rd_idx[i]) % 256);
                    check("rd_limit", i, (rd_idx[i] - beat_idx[i] - int'(pop_now)) < 2, 1);
                    if (rd_idx[i] == 0) first_rd_cyc[i] = cyc;
                    else if (all_ready)
                        check("rd_gap", i, since_rd[i],
                              ((rd_idx[i] - 1) % W == W - 1) ? hgap(i) : 0);
                    rd_idx[i]++;
                    since_rd[i] = 0;
                end else begin
                    since_rd[i]++;
                end
                final_prev[i] = pop_now && (beat_idx[i] == NPIX - 1);
                if (pop_now) beat_idx[i]++;
                vprev[i]   = tvalid[i];
                popprev[i] = pop_now;
                if (done[i]) clear_frame(i);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode: 0 = ready, timing checked; 1 = random ready; 2 = ready, timing unchecked
    task automatic run(input bit do_start, input int frames, input int mode,
                       input int poke_beat, input bit coincide);
        int  ndone [2];
        bit  b2b [2];
        int  n;
        bit  poked;
        bit  r;
        ndone = '{0, 0};
        b2b   = '{0, 0};
        n     = 0;
        poked = 1'b0;
        all_ready = (mode == 0);
        while ((ndone[0] < frames || ndone[1] < frames) && n < 600) begin
            for (int i = 0; i < 2; i++) begin
                start[i] = (do_start && n == 0) || b2b[i] || (coincide && final_prev[i]);
                b2b[i]   = 1'b0;
            end
            if (!poked && poke_beat >= 0 && beat_idx[0] == poke_beat) begin
                check("busy_mid", 0, busy[0], 1);
                check("busy_mid", 1, busy[1], 1);
                start = 2'b11;
                poked = 1'b1;
            end
            r = (mode == 1) ? 1'($urandom_range(1, 0)) : 1'b1;
            tready = {r, r};
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (done[i]) begin
                    ndone[i]++;
                    if (ndone[i] < frames) b2b[i] = 1'b1;
                end
            end
            tick();
            n++;
        end
        start = 2'b00;
        if (n >= 600) check("timeout", 0, n, 0);
        @(negedge clk);
        check("busy_after", 0, busy[0], 0);
        check("busy_after", 1, busy[1], 0);
        tick();
    endtask

    initial begin
        int n;
        rst    = 1'b1;
        start  = 2'b00;
        tready = 2'b00;
        repeat (2) tick();
        @(negedge clk);
        check("reset_outs", 0, outs(0), 0);
        check("reset_outs", 1, outs(1), 0);
        tick();
        rst = 1'b0;
        tick();

        // Basic frame, always ready
        run(1'b1, 1, 0, -1, 1'b0);
        // Random backpressure
        run(1'b1, 1, 1, -1, 1'b0);
        run(1'b1, 1, 1, -1, 1'b0);

        // Long stall on the tuser beat
        all_ready = 1'b0;
        tready = 2'b00;
        start  = 2'b11;
        tick();
        start = 2'b00;
        n = 0;
        while (n < 10) begin
            @(negedge clk);
            if (tvalid[0]) break;
            tick();
            n++;
        end
        if (n >= 10) check("stall_timeout", 0, n, 0);
        repeat (20) tick();
        @(negedge clk);
        check("stall_data", 0, tdata[0], 8'h10);
        check("stall_user", 0, tuser[0], 1);
        check("stall_reads", 0, rd_idx[0], 2);
        check("stall_reads", 1, rd_idx[1], 2);
        tick();
        run(1'b0, 1, 2, -1, 1'b0);

        // Start while busy at beat 5, plus start coincident with done
        run(1'b1, 1, 0, 5, 1'b1);
        repeat (4) begin
            @(negedge clk);
            check("idle_busy", 0, busy[0], 0);
            check("idle_busy", 1, busy[1], 0);
            check("idle_rd", 0, rd_en[0], 0);
            check("idle_rd", 1, rd_en[1], 0);
            tick();
        end

        // Back-to-back frames
        run(1'b1, 2, 0, -1, 1'b0);

        // Reset mid-frame, then a fresh frame
        all_ready = 1'b0;
        tready = 2'b11;
        start  = 2'b11;
        tick();
        start = 2'b00;
        n = 0;
        while (beat_idx[0] < 7 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check("abort_timeout", 0, n, 0);
        rst = 1'b1;
        @(negedge clk);
        check("abort_outs", 0, outs(0), 0);
        check("abort_outs", 1, outs(1), 0);
        tick();
        @(negedge clk);
        check("abort_outs", 0, outs(0), 0);
        check("abort_outs", 1, outs(1), 0);
        tick();
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_valid", 0, tvalid[0], 0);
            check("post_rst_valid", 1, tvalid[1], 0);
            tick();
        end
        run(1'b1, 1, 0, -1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
